// File: rtl/pdm_mic_frontend_if.sv
// PCM sample stream between the microphone front end and its consumer.
//   sample        signed PCM sample (producer -> consumer)
//   sample_valid  sample holds an untransferred result (producer -> consumer)
//   sample_ready  consumer accepts this cycle (consumer -> producer)
//   overrun       sticky lost-sample flag (producer -> consumer)
interface pdm_mic_frontend_if #(
    parameter int OUT_W = 8
);
    logic signed [OUT_W-1:0] sample;
    logic                    sample_valid;
    logic                    sample_ready;
    logic                    overrun;

    modport master (output sample, output sample_valid, output overrun, input sample_ready);
    modport slave  (input sample, input sample_valid, input overrun, output sample_ready);
endinterface

// File: rtl/pdm_mic_frontend.sv
// PDM microphone front end: generates pdm_clk, samples the 1-bit stream at
// the end of each high phase, decimates through a 2nd-order CIC and presents
// saturated signed PCM samples on a valid/ready stream with a sticky overrun.
//   clk, rst   system clock, synchronous active-high reset
//   en         run enable; low holds the capture path cleared
//   pdm_data   microphone data bit
//   pdm_clk    microphone clock
//   pcm        sample / sample_valid / sample_ready / overrun stream
module pdm_mic_frontend #(
    parameter int CLK_DIV = 4,
    parameter int DECIM   = 32,
    parameter int OUT_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                pdm_data,
    output logic                pdm_clk,
    pdm_mic_frontend_if.master  pcm
);
    localparam int LD    = $clog2(DECIM);
    localparam int W     = 2*LD + 2;
    localparam int SH    = 2*LD - (OUT_W-1);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic signed [W-1:0] PMAX = W'(2**(OUT_W-1) - 1);
    localparam logic signed [W-1:0] PMIN = -PMAX - W'(1);

    logic [DIV_W-1:0]    div_cnt;
    logic [LD-1:0]       bit_cnt;
    logic signed [W-1:0] i1, i2, i2_d, c1_d;
    logic                decim_tick;

    logic                div_last, strobe, load;
    logic signed [W-1:0] xs, i1_n, c1, c2, sh;
    logic [OUT_W-1:0]    r;

    assign div_last = (div_cnt == DIV_W'(CLK_DIV-1));
    // Bit strobe: last cycle of the pdm_clk high phase.
    assign strobe   = div_last && pdm_clk;
    assign xs       = pdm_data ? W'(1) : {W{1'b1}};
    assign i1_n     = i1 + xs;
    // Comb runs on the cycle decim_tick is high; i2 already holds the last bit.
    assign c1       = i2 - i2_d;
    assign c2       = c1 - c1_d;
    assign load     = en && decim_tick;

    always_comb begin
        sh = c2 >>> SH;
        if (sh > PMAX)      r = PMAX[OUT_W-1:0];
        else if (sh < PMIN) r = PMIN[OUT_W-1:0];
        else                r = sh[OUT_W-1:0];
    end

    // Capture path: en low behaves like reset so en rising restarts timing.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            div_cnt    <= '0;
            pdm_clk    <= 1'b0;
            bit_cnt    <= '0;
            i1         <= '0;
            i2         <= '0;
            i2_d       <= '0;
            c1_d       <= '0;
            decim_tick <= 1'b0;
        end else begin
            if (div_last) begin
                div_cnt <= '0;
                pdm_clk <= ~pdm_clk;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
            if (strobe) begin
                i1      <= i1_n;
                i2      <= i2 + i1_n;   // second stage accumulates the updated i1
                bit_cnt <= bit_cnt + LD'(1);
            end
            decim_tick <= strobe && (bit_cnt == {LD{1'b1}});
            if (decim_tick) begin
                i2_d <= i2;
                c1_d <= c1;
            end
        end
    end

    // Output stage keeps running with en low so a pending sample can drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcm.sample       <= '0;
            pcm.sample_valid <= 1'b0;
            pcm.overrun      <= 1'b0;
        end else if (load) begin
            pcm.sample       <= r;
            pcm.sample_valid <= 1'b1;
            if (pcm.sample_valid && !pcm.sample_ready) pcm.overrun <= 1'b1;
        end else if (pcm.sample_valid && pcm.sample_ready) begin
            pcm.sample_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pdm_mic_frontend.sv
module tb_pdm_mic_frontend;
    localparam int CLK_DIV = 4;
    localparam int DECIM   = 32;
    localparam int OUT_W   = 8;
    localparam int SH      = 2*$clog2(DECIM) - (OUT_W-1);

    logic clk = 0, rst = 1, en = 1, pdm_data = 0;
    logic pdm_clk;
    pdm_mic_frontend_if #(.OUT_W(OUT_W)) pcm_if();

    pdm_mic_frontend #(.CLK_DIV(CLK_DIV), .DECIM(DECIM), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst(rst), .en(en), .pdm_data(pdm_data),
        .pdm_clk(pdm_clk), .pcm(pcm_if)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    bit alt_mode = 0, rnd_mode = 0, started = 0;
    int bias = 8;

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: CIC2 as a triangular FIR over the current and previous
    // frame of +/-1 bits (history before reset/en is zero), then scale+clamp.
    int m_cur[DECIM], m_prev[DECIM];
    int m_t, m_nb, m_pval, m_sample;
    bit m_pend, m_valid, m_ovr, m_pclk, m_ld;

    function automatic int cic_out();
        int y = 0;
        int r;
        for (int j = 0; j < DECIM; j++) y += m_cur[j]*(DECIM-j) + m_prev[j]*j;
        r = y >>> SH;
        if (r > 2**(OUT_W-1)-1) r = 2**(OUT_W-1)-1;
        if (r < -(2**(OUT_W-1))) r = -(2**(OUT_W-1));
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_t = 0; m_nb = 0; m_pend = 0; m_valid = 0; m_ovr = 0; m_sample = 0; m_pclk = 0;
            foreach (m_prev[j]) m_prev[j] = 0;
        end else begin
            m_ld = en && m_pend;
            if (m_ld) begin
                if (m_valid && !pcm_if.sample_ready) m_ovr = 1;
                m_sample = m_pval;
                m_valid  = 1;
            end else if (m_valid && pcm_if.sample_ready) begin
                m_valid = 0;
            end
            m_pend = 0;
            if (en) begin
                m_t++;
                m_pclk = ((m_t / CLK_DIV) % 2) == 1;
                if (m_t % (2*CLK_DIV) == 0) begin
                    m_cur[m_nb] = pdm_data ? 1 : -1;
                    m_nb++;
                    if (m_nb == DECIM) begin
                        m_pval = cic_out();
                        m_pend = 1;
                        m_prev = m_cur;
                        m_nb   = 0;
                    end
                end
            end else begin
                m_t = 0; m_nb = 0; m_pclk = 0;
                foreach (m_prev[j]) m_prev[j] = 0;
            end
        end
        started = 1;
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(posedge clk) begin
        #1;
        if (started) begin
            chk("pdm_clk", 32'(pdm_clk), 32'(m_pclk));
            chk("sample_valid", 32'(pcm_if.sample_valid), 32'(m_valid));
            chk("overrun", 32'(pcm_if.overrun), 32'(m_ovr));
            if (m_valid) chk("sample", 32'(pcm_if.sample), m_sample);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            if (alt_mode) pdm_data = (m_nb % 2 == 0);
            if (rnd_mode) begin
                pdm_data = ($urandom % 16) < bias;
                pcm_if.sample_ready = ($urandom % 4) != 0;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1;
        step(3);
        rst = 0;
    endtask

    initial begin
        pcm_if.sample_ready = 1;
        step(3);
        chk("reset_pdm_clk", 32'(pdm_clk), 0);
        chk("reset_valid", 32'(pcm_if.sample_valid), 0);
        chk("reset_sample", 32'(pcm_if.sample), 0);
        chk("reset_overrun", 32'(pcm_if.overrun), 0);

        // Constant ones, consumer always ready.
        pdm_data = 1; rst = 0;
        step(3);   chk("pclk_edge3", 32'(pdm_clk), 0);
        step(1);   chk("pclk_edge4", 32'(pdm_clk), 1);
        step(252); chk("ones_valid_256", 32'(pcm_if.sample_valid), 0);
        step(1);   chk("ones_valid_257", 32'(pcm_if.sample_valid), 1);
                   chk("ones_first", 32'(pcm_if.sample), 66);
        step(1);   chk("ones_valid_258", 32'(pcm_if.sample_valid), 0);
        step(255); chk("ones_second", 32'(pcm_if.sample), 127);
                   chk("ones_ovr", 32'(pcm_if.overrun), 0);

        // Constant zeros.
        pdm_data = 0; do_reset();
        step(257); chk("zeros_first", 32'(pcm_if.sample), -66);
        step(256); chk("zeros_second", 32'(pcm_if.sample), -128);

        // Alternating 1,0,... starting with 1.
        alt_mode = 1; pdm_data = 1; do_reset();
        step(257); chk("alt_first", 32'(pcm_if.sample), 2);
        step(256); chk("alt_second", 32'(pcm_if.sample), 0);
                   chk("alt_valid", 32'(pcm_if.sample_valid), 1);
        alt_mode = 0;

        // Backpressure.
        pdm_data = 1; pcm_if.sample_ready = 0; do_reset();
        step(257); chk("bp_first", 32'(pcm_if.sample), 66);
                   chk("bp_ovr0", 32'(pcm_if.overrun), 0);
        step(256); chk("bp_second", 32'(pcm_if.sample), 127);
                   chk("bp_ovr1", 32'(pcm_if.overrun), 1);
        pcm_if.sample_ready = 1;
        step(1);   chk("bp_drop", 32'(pcm_if.sample_valid), 0);
        pcm_if.sample_ready = 0;
        step(50);  chk("bp_sticky", 32'(pcm_if.overrun), 1);

        // Mid-frame reset after 20 bits.
        pcm_if.sample_ready = 1; do_reset();
        step(160); do_reset();
        step(256); chk("mf_rst_valid256", 32'(pcm_if.sample_valid), 0);
        step(1);   chk("mf_rst_first", 32'(pcm_if.sample), 66);

        // en low mid-frame with a pending sample.
        pcm_if.sample_ready = 0; do_reset();
        step(257); chk("en_pending", 32'(pcm_if.sample), 66);
        step(100);
        en = 0;
        step(10);  chk("en_off_pclk", 32'(pdm_clk), 0);
                   chk("en_off_valid", 32'(pcm_if.sample_valid), 1);
                   chk("en_off_sample", 32'(pcm_if.sample), 66);
        en = 1;
        step(3);   chk("en_pclk3", 32'(pdm_clk), 0);
        step(1);   chk("en_pclk4", 32'(pdm_clk), 1);
        step(252); chk("en_ovr256", 32'(pcm_if.overrun), 0);
        step(1);   chk("en_ovr257", 32'(pcm_if.overrun), 1);
                   chk("en_restart_sample", 32'(pcm_if.sample), 66);

        // Randomized traffic with varying density, en dips and resets.
        rnd_mode = 1;
        for (int k = 0; k < 5000; k++) begin
            if (k % 256 == 0) bias = $urandom_range(0, 16);
            if ($urandom % 700 == 0) en = 0;
            else if (!en && ($urandom % 8 == 0)) en = 1;
            rst = ($urandom % 1800 == 0);
            step(1);
        end
        rst = 0; en = 1; rnd_mode = 0;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
